// File: rtl/hit_rate_counters_pkg.sv
// Shared definitions for the hit-rate counter bank and the JTAG side that reads it.
package hit_rate_counters_pkg;

  // Default bank geometry: 14 channels of 16 bits fill the 224-bit hcounters bus.
  localparam int N_CH     = 14;
  localparam int CNT_W    = 16;
  localparam int GATE_LEN = 40000000;
  localparam int WIN_W    = 26;
  localparam int HCNT_W   = N_CH * CNT_W;

  // TAP instruction that captures hcounters; kept here so both sides use the same code.
  localparam int unsigned TAP_CNREAD = 17;

  // Bit offset of channel k inside the hcounters bus.
  function automatic int ch_offset(input int k, input int cnt_w);
    return k * cnt_w;
  endfunction

endpackage

// File: rtl/hit_rate_counters_if.sv
// Bundle of the counter bank's data-path signals. The master side supplies hits
// and TCK-domain controls; the slave side (the counter bank) returns the snapshot.
interface hit_rate_counters_if #(
  parameter int N_CH  = hit_rate_counters_pkg::N_CH,
  parameter int CNT_W = hit_rate_counters_pkg::CNT_W
) ();

  logic [N_CH-1:0]       hit;
  logic                  input_dis;
  logic                  clr_tgl;
  logic [N_CH*CNT_W-1:0] hcounters;
  logic [N_CH-1:0]       ovf;
  logic                  snap_stb;

  modport master (
    output hit,
    output input_dis,
    output clr_tgl,
    input  hcounters,
    input  ovf,
    input  snap_stb
  );

  modport slave (
    input  hit,
    input  input_dis,
    input  clr_tgl,
    output hcounters,
    output ovf,
    output snap_stb
  );

endinterface

// File: rtl/hit_rate_counters_sat_counter.sv
// One channel's saturating accumulator with a sticky "saturated this window" flag.
// sat_set also reflects an increment attempted at the ceiling in the current cycle,
// so a snapshot taken on that same edge still reports the overflow.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             load_zero,
  output logic [CNT_W-1:0] q,
  output logic             sat_set
);

  logic [CNT_W-1:0] r_acc;
  logic             r_sat;
  logic             w_at_max;

  assign w_at_max = (r_acc == '1);

  // Accumulate increments until the ceiling; remember any increment lost to saturation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else if (clr || load_zero) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else if (inc) begin
      if (w_at_max) begin
        r_sat <= 1'b1;
      end else begin
        r_acc <= r_acc + CNT_W'(1);
      end
    end
  end

  assign q       = r_acc;
  assign sat_set = r_sat | (inc & w_at_max);

endmodule

// File: rtl/hit_rate_counters.sv
// Per-channel hit-rate counter bank: counts hits over a fixed gate window and
// publishes a snapshot that only changes at window boundaries or on a clear.
module hit_rate_counters #(
  parameter int N_CH     = hit_rate_counters_pkg::N_CH,
  parameter int CNT_W    = hit_rate_counters_pkg::CNT_W,
  parameter int GATE_LEN = hit_rate_counters_pkg::GATE_LEN,
  parameter int WIN_W    = hit_rate_counters_pkg::WIN_W
) (
  input logic                clk,
  input logic                rst,
  hit_rate_counters_if.slave bus
);
  import hit_rate_counters_pkg::*;

  localparam int              HC_W     = N_CH * CNT_W;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(GATE_LEN - 1);

  logic             r_dis_q1;
  logic             r_dis_q2;
  logic             r_clr_q1;
  logic             r_clr_q2;
  logic             r_clr_q3;
  logic             w_dis_s;
  logic             w_clr_p;
  logic             w_win_end;
  logic [WIN_W-1:0] r_wcnt;
  logic [N_CH-1:0]  w_inc;
  logic [N_CH-1:0]  w_sat_set;
  logic [HC_W-1:0]  w_snap_val;
  logic [HC_W-1:0]  r_hcounters;
  logic [N_CH-1:0]  r_ovf;
  logic             r_snap_stb;

  // Bring the TCK-domain disable level and clear toggle into clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dis_q1 <= 1'b0;
      r_dis_q2 <= 1'b0;
      r_clr_q1 <= 1'b0;
      r_clr_q2 <= 1'b0;
      r_clr_q3 <= 1'b0;
    end else begin
      r_dis_q1 <= bus.input_dis;
      r_dis_q2 <= r_dis_q1;
      r_clr_q1 <= bus.clr_tgl;
      r_clr_q2 <= r_clr_q1;
      r_clr_q3 <= r_clr_q2;
    end
  end

  assign w_dis_s   = r_dis_q2;
  assign w_clr_p   = r_clr_q2 ^ r_clr_q3;
  assign w_win_end = (r_wcnt == WIN_LAST);

  // Gate window counter; a clear restarts the window from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt <= '0;
    end else if (w_clr_p || w_win_end) begin
      r_wcnt <= '0;
    end else begin
      r_wcnt <= r_wcnt + WIN_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      localparam int OFS = ch_offset(gi, CNT_W);
      logic [CNT_W-1:0] w_q;

      assign w_inc[gi] = bus.hit[gi] & ~w_dis_s;

      sat_counter #(
        .CNT_W(CNT_W)
      ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_clr_p),
        .inc      (w_inc[gi]),
        .load_zero(w_win_end),
        .q        (w_q),
        .sat_set  (w_sat_set[gi])
      );

      // Value published at window end includes a hit landing in the win_end cycle.
      assign w_snap_val[OFS +: CNT_W] = (w_inc[gi] && (w_q != '1)) ? (w_q + CNT_W'(1)) : w_q;
    end
  endgenerate

  // Snapshot register: loads at window end, zeroes on clear, otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcounters <= '0;
      r_ovf       <= '0;
      r_snap_stb  <= 1'b0;
    end else if (w_clr_p) begin
      r_hcounters <= '0;
      r_ovf       <= '0;
      r_snap_stb  <= 1'b0;
    end else if (w_win_end) begin
      r_hcounters <= w_snap_val;
      r_ovf       <= w_sat_set;
      r_snap_stb  <= 1'b1;
    end else begin
      r_snap_stb  <= 1'b0;
    end
  end

  assign bus.hcounters = r_hcounters;
  assign bus.ovf       = r_ovf;
  assign bus.snap_stb  = r_snap_stb;

endmodule

// File: tb/tb_hit_rate_counters.sv
// Directed bench for hit_rate_counters. Instance A: 16-bit counters, 16-cycle window.
// Instance B: 4-bit counters, 32-cycle window (saturation cases).
module tb_hit_rate_counters;
  import hit_rate_counters_pkg::*;

  localparam int NC   = 14;
  localparam int A_W  = 16;
  localparam int A_G  = 16;
  localparam int A_WW = 4;
  localparam int B_W  = 4;
  localparam int B_G  = 32;
  localparam int B_WW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [NC*A_W-1:0] exp_a;
  logic [NC*B_W-1:0] exp_b;

  always #5 clk = ~clk;

  hit_rate_counters_if #(.N_CH(NC), .CNT_W(A_W)) ifa ();
  hit_rate_counters_if #(.N_CH(NC), .CNT_W(B_W)) ifb ();

  hit_rate_counters #(
    .N_CH(NC), .CNT_W(A_W), .GATE_LEN(A_G), .WIN_W(A_WW)
  ) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(ifa)
  );

  hit_rate_counters #(
    .N_CH(NC), .CNT_W(B_W), .GATE_LEN(B_G), .WIN_W(B_WW)
  ) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(ifb)
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end else begin
      $display("chk  %s = %0h ok (cyc %0d)", tag, got, cyc);
    end
  endtask

  // Advance one clock edge; outputs are read 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    ifa.hit       = '0;
    ifa.input_dis = 1'b0;
    ifa.clr_tgl   = 1'b0;
    ifb.hit       = '0;
    ifb.input_dis = 1'b0;
    ifb.clr_tgl   = 1'b0;
    step();
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- Basic count ----------------
    do_reset();
    while (cyc < 16) begin
      ifa.hit    = '0;
      ifa.hit[0] = 1'b1;
      ifa.hit[3] = (cyc >= 2 && cyc <= 6);
      step();
      if (cyc == 15) check_eq("basic_no_early_stb", 256'(ifa.snap_stb), 256'(0));
    end
    exp_a = '0;
    exp_a[ch_offset(0, A_W) +: A_W] = 16'd16;
    exp_a[ch_offset(3, A_W) +: A_W] = 16'd5;
    check_eq("basic_snap", 256'(ifa.hcounters), 256'(exp_a));
    check_eq("basic_ovf", 256'(ifa.ovf), 256'(0));
    check_eq("basic_stb", 256'(ifa.snap_stb), 256'(1));
    ifa.hit = '0;
    step();
    check_eq("basic_stb_one_cycle", 256'(ifa.snap_stb), 256'(0));
    check_eq("basic_hold", 256'(ifa.hcounters), 256'(exp_a));
    while (cyc < 32) step();
    check_eq("basic_next_zero", 256'(ifa.hcounters), 256'(0));
    check_eq("basic_next_stb", 256'(ifa.snap_stb), 256'(1));

    // ---------------- Asynchronous reset mid-window ----------------
    do_reset();
    while (cyc < 21) begin
      ifa.hit    = '0;
      ifa.hit[4] = (cyc < 16);
      step();
    end
    exp_a = '0;
    exp_a[ch_offset(4, A_W) +: A_W] = 16'd16;
    check_eq("rst_pre_snap", 256'(ifa.hcounters), 256'(exp_a));
    rst = 1'b1;
    #1;
    check_eq("rst_async_hc", 256'(ifa.hcounters), 256'(0));
    check_eq("rst_async_ovf", 256'(ifa.ovf), 256'(0));
    check_eq("rst_async_stb", 256'(ifa.snap_stb), 256'(0));
    ifa.hit = '0;
    step();
    rst = 1'b0;
    cyc = 0;
    while (cyc < 16) begin
      ifa.hit    = '0;
      ifa.hit[5] = (cyc == 15);
      step();
      if (cyc == 15) check_eq("rst_wcnt_no_early_stb", 256'(ifa.snap_stb), 256'(0));
    end
    exp_a = '0;
    exp_a[ch_offset(5, A_W) +: A_W] = 16'd1;
    check_eq("rst_wcnt_restart_snap", 256'(ifa.hcounters), 256'(exp_a));
    check_eq("rst_wcnt_restart_stb", 256'(ifa.snap_stb), 256'(1));

    // ---------------- Saturation (4-bit counters, 32-cycle window) ----------------
    do_reset();
    while (cyc < 128) begin
      ifb.hit    = '0;
      ifb.hit[1] = (cyc < 32) ||
                   (cyc == 40 || cyc == 41 || cyc == 50) ||
                   (cyc >= 64 && cyc <= 78) ||
                   (cyc >= 96 && cyc <= 110) || (cyc == 127);
      step();
      if (cyc == 32) begin
        exp_b = '0;
        exp_b[ch_offset(1, B_W) +: B_W] = 4'd15;
        check_eq("sat_full_val", 256'(ifb.hcounters), 256'(exp_b));
        check_eq("sat_full_ovf", 256'(ifb.ovf), 256'(14'b00_0000_0000_0010));
      end
      if (cyc == 64) begin
        exp_b = '0;
        exp_b[ch_offset(1, B_W) +: B_W] = 4'd3;
        check_eq("sat_after_val", 256'(ifb.hcounters), 256'(exp_b));
        check_eq("sat_after_ovf", 256'(ifb.ovf), 256'(0));
      end
      if (cyc == 96) begin
        exp_b = '0;
        exp_b[ch_offset(1, B_W) +: B_W] = 4'd15;
        check_eq("sat_exact_max_val", 256'(ifb.hcounters), 256'(exp_b));
        check_eq("sat_exact_max_ovf", 256'(ifb.ovf), 256'(0));
      end
    end
    exp_b = '0;
    exp_b[ch_offset(1, B_W) +: B_W] = 4'd15;
    check_eq("sat_winend_val", 256'(ifb.hcounters), 256'(exp_b));
    check_eq("sat_winend_ovf", 256'(ifb.ovf), 256'(14'b00_0000_0000_0010));

    // ---------------- Input disable with 2-flop lag ----------------
    do_reset();
    while (cyc < 16) begin
      ifa.hit       = '0;
      ifa.hit[0]    = 1'b1;
      ifa.hit[2]    = (cyc == 3);
      ifa.hit[4]    = (cyc == 4);
      ifa.hit[5]    = (cyc == 9);
      ifa.hit[6]    = (cyc == 10);
      ifa.input_dis = (cyc >= 2 && cyc <= 7);
      step();
    end
    exp_a = '0;
    exp_a[ch_offset(0, A_W) +: A_W] = 16'd10;
    exp_a[ch_offset(2, A_W) +: A_W] = 16'd1;
    exp_a[ch_offset(6, A_W) +: A_W] = 16'd1;
    check_eq("dis_snap", 256'(ifa.hcounters), 256'(exp_a));
    ifa.input_dis = 1'b0;

    // ---------------- Clear coinciding with window end ----------------
    do_reset();
    while (cyc < 48) begin
      ifa.hit    = '0;
      ifa.hit[2] = 1'b1;
      if (cyc == 29) ifa.clr_tgl = ~ifa.clr_tgl;
      step();
      exp_a = '0;
      exp_a[ch_offset(2, A_W) +: A_W] = 16'd16;
      if (cyc == 16) check_eq("clrwe_first_snap", 256'(ifa.hcounters), 256'(exp_a));
      if (cyc == 31) check_eq("clrwe_hold", 256'(ifa.hcounters), 256'(exp_a));
      if (cyc == 32) begin
        check_eq("clrwe_hc_zero", 256'(ifa.hcounters), 256'(0));
        check_eq("clrwe_no_stb", 256'(ifa.snap_stb), 256'(0));
        check_eq("clrwe_ovf_zero", 256'(ifa.ovf), 256'(0));
      end
      if (cyc == 47) check_eq("clrwe_no_early_stb", 256'(ifa.snap_stb), 256'(0));
      if (cyc == 48) begin
        check_eq("clrwe_full_window", 256'(ifa.hcounters), 256'(exp_a));
        check_eq("clrwe_next_stb", 256'(ifa.snap_stb), 256'(1));
      end
    end

    // ---------------- Clear latency, two toggles 10 cycles apart ----------------
    do_reset();
    while (cyc < 46) begin
      ifa.hit    = '0;
      ifa.hit[1] = 1'b1;
      if (cyc == 17 || cyc == 27) ifa.clr_tgl = ~ifa.clr_tgl;
      step();
      exp_a = '0;
      exp_a[ch_offset(1, A_W) +: A_W] = 16'd16;
      if (cyc == 16) check_eq("clrlat_pre_snap", 256'(ifa.hcounters), 256'(exp_a));
      if (cyc == 19) check_eq("clrlat1_not_yet", 256'(ifa.hcounters), 256'(exp_a));
      if (cyc == 20) check_eq("clrlat1_zero", 256'(ifa.hcounters), 256'(0));
      if (cyc == 30) check_eq("clrlat2_zero", 256'(ifa.hcounters), 256'(0));
      if (cyc == 36) check_eq("clrlat2_window_restart", 256'(ifa.snap_stb), 256'(0));
      if (cyc == 45) check_eq("clrlat2_no_early_stb", 256'(ifa.snap_stb), 256'(0));
    end
    check_eq("clrlat2_snap", 256'(ifa.hcounters), 256'(exp_a));
    check_eq("clrlat2_stb", 256'(ifa.snap_stb), 256'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hit_rate_counters.md
Name: hit_rate_counters

Overview:
- Per-channel hit-rate counter bank in the `clk` domain.
- Counts hit pulses over a fixed gate window and publishes a stable snapshot on the `hcounters` bus, which the JTAG block captures on CNread.
- Clear and input-disable requests arrive from the TCK domain as toggle or level signals and are synchronized here.
- The snapshot changes only at window boundaries, so asynchronous capture by TCK logic sees a value that is stable for a whole window.

Parameters:
- N_CH, 14, number of counted channels; N_CH*CNT_W must equal the hcounters bus width (224).
- CNT_W, 16, width of each counter.
- GATE_LEN, 40000000, gate window length in clk cycles; must be ≥ 2.
- WIN_W, 26, width of the window counter; must satisfy 2^WIN_W > GATE_LEN-1.

Ports:
- clk  in  1  system clock (40 MHz).
- rst  in  1  asynchronous, active-high reset.
- hit  in  N_CH  per-channel hit strobe; a 1 adds one count in that cycle.
- input_dis  in  1  level from the TCK domain; 1 suppresses counting.
- clr_tgl  in  1  toggle from the TCK domain; each edge requests a clear.
- hcounters  out  N_CH*CNT_W  snapshot; channel k occupies bits [k*CNT_W +: CNT_W].
- ovf  out  N_CH  per-channel flag: counter saturated during the published window.
- snap_stb  out  1  one-cycle pulse in the cycle after hcounters/ovf update.

Behaviour:
- Reset: clk single clock; rst async active-high. Reset asserted clears to 0: hcounters, ovf, snap_stb, all accumulators, the window counter and the sticky flags. Synchronizer flops reset to 0. All registers assert/deassert asynchronously on rst.
- Synchronizers:
  - input_dis passes through a 2-flop chain; dis_s is the output of the second flop.
  - clr_tgl passes through a 3-flop chain q1/q2/q3; clr_p = q2 ^ q3.
  - A clr_tgl edge before clk edge 1 produces clr_p=1 after edge 2 and takes effect at edge 3.
  - If clr_tgl toggles at reset release with q1..q3 = 0, the first clear fires 3 edges later.
- Window counter:
  - wcnt counts 0..GATE_LEN-1 and wraps to 0.
  - win_end = (wcnt == GATE_LEN-1).
  - Counting runs regardless of dis_s.
- Accumulators acc[k], CNT_W bits each:
  - When dis_s=0 and hit[k]=1, acc[k] increments by 1.
  - acc[k] saturates at 2^CNT_W-1; it never wraps.
  - An increment attempted while acc[k] is at max sets sticky sat[k].
- Window end (win_end=1, clr_p=0), all effective at the same edge:
  - hcounters[k] <= acc[k] + (dis_s=0 ? hit[k] : 0), saturated.
  - ovf[k] <= sat[k] OR (saturating increment this cycle).
  - acc <= 0, sat <= 0, wcnt <= 0.
  - snap_stb <= 1 for exactly one cycle.
- A hit in the win_end cycle is counted in the closing window.
- Clear (clr_p=1):
  - acc, sat, wcnt, hcounters and ovf are all set to 0; snap_stb <= 0.
  - Clear has priority over win_end and over any hit in the same cycle; that hit is dropped.
  - The next window starts from wcnt=0 on the following edge.
- Between window ends and clears, hcounters and ovf hold their values.
- dis_s toggling mid-window affects only the cycles in which it is 1; there is no partial-window flag.
- Latency:
  - hit at cycle t is visible in the snapshot at the first win_end edge ≥ t.
  - A clr_tgl edge takes effect 3 clk edges later.

Decomposition:
- Shared package holds:
  - constants N_CH, CNT_W, GATE_LEN;
  - the hcounters slice helper (channel k offset = k*CNT_W);
  - the TAP instruction code CNread=17, so the JTAG side and this block agree.
- One sub-module, sat_counter, instantiated N_CH times:
  - ports: clk, rst, clr, inc, load_zero, q[CNT_W], sat_set;
  - holds the saturating accumulator and its sticky flag.
- The window counter and synchronizers stay in the top level.

Test Plan:
- Reset: assert rst mid-window with GATE_LEN=16 -> hcounters=0, ovf=0 and snap_stb=0 immediately (asynchronous), and wcnt restarts at 0 after release.
- Basic count: GATE_LEN=16, channel 3 hit for 5 cycles, channel 0 for 16 cycles including the win_end cycle -> at window end hcounters[3]=5, hcounters[0]=16, others 0, snap_stb a single pulse, and the next window reads 0 if no hits.
- Saturation: CNT_W=4, GATE_LEN=32, channel 1 hit every cycle -> hcounters[1]=15 and ovf[1]=1; the following window with 3 hits gives hcounters[1]=3, ovf[1]=0.
- Disable: input_dis=1 for cycles 4..9 of a 16-cycle window with hits on every cycle -> count = 16-6 = 10, with the 2-cycle synchronizer lag checked exactly.
- Clear vs window end: toggle clr_tgl so clr_p coincides with win_end while channel 2 is hit -> hcounters all 0, no snap_stb, and the next window counts from 0 with a full GATE_LEN length.
- Clear latency: toggle clr_tgl twice, 10 cycles apart -> two clears, each effective exactly 3 edges after its toggle, and hcounters=0 after each.
